// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART FSM states, frame constants and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  // Total bits on the wire for one character: start + data + optional parity + stop.
  function automatic int frame_bits(input bit parity_en);
    return 1 + DATA_BITS + (parity_en ? 1 : 0) + 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, mid-bit sampling, valid/framing/parity strobes.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  // START is entered one cycle after the line is first seen low, so the midpoint comes one count early.
  localparam logic [CW-1:0] MID_LAST = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 w_rx_s;
  logic                 w_shift_en;
  logic                 w_perr_ld;
  logic                 w_valid_set;
  logic                 w_ferr_set;

  uart_sync2 #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (rx_in),
    .q    (w_rx_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_perr_ld   = 1'b0;
    w_valid_set = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == MID_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          w_idx_nxt  = r_idx + 3'd1;
          if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_perr_ld   = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_valid_set = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_data_valid <= w_valid_set;
      r_frame_err  <= w_ferr_set;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_valid_set) r_data_out <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  logic r_parity_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perr       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_perr_ld) r_perr <= w_rx_s ^ (^r_shift);
      r_parity_err <= w_valid_set & r_perr;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Self-checking bench for uart_rx with a per-cycle frame-timing model.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int H    = CPB / 2;
  localparam int MAXC = 4096;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = frame_bits(PAR);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit         exp_dv   [MAXC];
  bit         exp_fe   [MAXC];
  bit         exp_pe   [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_rst  [MAXC];
  logic [7:0] exp_byte [MAXC];
  logic [7:0] model_dout = 8'h00;

  int         dv_cycles[$];
  logic [7:0] dv_bytes[$];
  int         fe_count = 0;
  int         pe_count = 0;
  int         last_pe_cyc = -1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mark_busy(input int from, input int to);
    for (int i = from; i <= to; i++) exp_busy[i] = 1'b1;
  endtask

  // Frame starting (line falls) on cycle t0: E = t0+2, strobe one cycle after the stop-bit midpoint.
  task automatic predict_frame(input int t0, input logic [7:0] b, input bit stop_v,
                               input bit par_v, input int extra_low);
    int e;
    int s;
    e = t0 + 2;
    s = e + H + (FB - 1) * CPB;
    if (stop_v) begin
      exp_dv[s]   = 1'b1;
      exp_byte[s] = b;
      exp_pe[s]   = PAR && (par_v != ^b);
      mark_busy(e + 1, s - 1);
    end else begin
      exp_fe[s] = 1'b1;
      mark_busy(e + 1, t0 + FB * CPB + extra_low + 2);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_in = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_v,
                            input int extra_low);
    predict_frame(cyc, b, stop_v, par_v, extra_low);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (PAR) drive(par_v, CPB);
    drive(stop_v, CPB + (stop_v ? 0 : extra_low));
    rx_in = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cyc >= MAXC) begin
      errors++;
      $display("FAIL watchdog: cycle %0d reached limit %0d", cyc, MAXC);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      if (exp_rst[cyc]) model_dout = 8'h00;
      if (exp_dv[cyc])  model_dout = exp_byte[cyc];
      chk("data_valid", {7'd0, data_valid}, {7'd0, exp_dv[cyc]});
      chk("frame_err",  {7'd0, frame_err},  {7'd0, exp_fe[cyc]});
      chk("parity_err", {7'd0, parity_err}, {7'd0, exp_pe[cyc]});
      chk("busy",       {7'd0, busy},       {7'd0, exp_busy[cyc]});
      chk("data_out",   data_out,           model_dout);
      if (data_valid === 1'b1) begin
        dv_cycles.push_back(cyc);
        dv_bytes.push_back(data_out);
      end
      if (frame_err === 1'b1) fe_count++;
      if (parity_err === 1'b1) begin
        pe_count++;
        last_pe_cyc = cyc;
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < MAXC; i++) begin
      exp_dv[i]   = 1'b0;
      exp_fe[i]   = 1'b0;
      exp_pe[i]   = 1'b0;
      exp_busy[i] = 1'b0;
      exp_rst[i]  = 1'b0;
      exp_byte[i] = 8'h00;
    end
    @(posedge clk);
    #2;
    tick(3);
    lit("rst_data_out", int'(data_out), 0);
    lit("rst_busy", int'(busy), 0);
    lit("rst_strobes", int'({data_valid, frame_err, parity_err}), 0);
    reset = 1'b1;
    tick(10);

    // Single byte
    t0 = cyc;
    send_frame(8'hA5, 1'b1, ^8'hA5, 0);
    tick(30);
    lit("a5_count", dv_cycles.size(), 1);
    lit("a5_latency", dv_cycles[$] - t0, PAR ? 170 : 154);
    lit("a5_data", int'(dv_bytes[$]), 'hA5);

    // Back-to-back, zero idle gap
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    tick(30);
    lit("b2b_count", dv_cycles.size(), 3);
    lit("b2b_spacing", dv_cycles[2] - dv_cycles[1], PAR ? 176 : 160);
    lit("b2b_first", int'(dv_bytes[1]), 'h00);
    lit("b2b_second", int'(data_out), 'hFF);

    // Glitch rejection
    t0 = cyc;
    mark_busy(t0 + 3, t0 + 2 + H - 1);
    drive(1'b0, 4);
    drive(1'b1, 40);
    lit("glitch_no_valid", dv_cycles.size(), 3);
    lit("glitch_no_ferr", fe_count, 0);
    lit("glitch_idle", int'(busy), 0);

    // Framing error with a 40-clock break, then recovery
    send_frame(8'h3C, 1'b0, ^8'h3C, 40);
    tick(30);
    lit("ferr_count", fe_count, 1);
    lit("ferr_keep_data", int'(data_out), 'hFF);
    lit("ferr_no_valid", dv_cycles.size(), 3);
    send_frame(8'h11, 1'b1, ^8'h11, 0);
    tick(30);
    lit("recover_data", int'(data_out), 'h11);
    lit("recover_count", dv_cycles.size(), 4);

    // Reset during data bit 4
    predict_frame(cyc, 8'h5A, 1'b1, 1'b0, 0);
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(t0[0] | 1'b0 ? 1'b0 : 1'b0 | (8'h5A >> i) & 1'b1, CPB);
    drive(1'b1, H);
    reset = 1'b0;
    for (int i = cyc; i < MAXC; i++) begin
      exp_dv[i]   = 1'b0;
      exp_fe[i]   = 1'b0;
      exp_pe[i]   = 1'b0;
      exp_busy[i] = 1'b0;
    end
    exp_rst[cyc] = 1'b1;
    #1;
    lit("midrst_data_out", int'(data_out), 0);
    lit("midrst_outputs", int'({data_valid, frame_err, parity_err, busy}), 0);
    tick(3);
    rx_in = 1'b1;
    reset = 1'b1;
    tick(250);
    lit("midrst_no_valid", dv_cycles.size(), 4);
    lit("midrst_no_ferr", fe_count, 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0);
    tick(30);
    lit("par_ok_valid", dv_cycles.size(), 5);
    lit("par_ok_no_perr", pe_count, 0);
    send_frame(8'h07, 1'b1, 1'b0, 0);
    tick(30);
    lit("par_bad_valid", dv_cycles.size(), 6);
    lit("par_bad_perr", pe_count, 1);
    lit("par_same_cycle", last_pe_cyc, dv_cycles[$]);
    lit("par_bad_data", int'(data_out), 'h07);
`else
    lit("no_parity_strobe", pe_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
